// File: rtl/fma_psum_pkg.sv
// Shared definitions for the per-PE partial-sum context stage.
// The FP width default is shared with the FP FMA wrapper.
package fma_psum_pkg;

    localparam int FP_W_DEFAULT = 16;

    localparam logic [FP_W_DEFAULT-1:0] FP_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC      = 2'd1,
        ACC_FULL = 2'd2
    } psum_state_e;

endpackage

// File: rtl/psum_shadow_reg.sv
// Shadow register of one PE: holds a finished partial sum and forms one
// link of the column shift-out chain. A capture always wins over a shift.
module psum_shadow_reg #(
    parameter int FP_W = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            capture_i,
    input  logic [FP_W-1:0] capture_data_i,
    input  logic            shift_i,
    input  logic [FP_W-1:0] shift_data_i,
    input  logic            shift_vld_i,
    output logic [FP_W-1:0] data_o,
    output logic            vld_o
);

    logic [FP_W-1:0] data_q, data_d;
    logic            vld_q, vld_d;

    // Next shadow contents: local capture first, upstream shift second, else hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (capture_i) begin
            data_d = capture_data_i;
            vld_d  = 1'b1;
        end else if (shift_i) begin
            data_d = shift_data_i;
            vld_d  = shift_vld_i;
        end
    end

    // Shadow data/valid storage with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/fma_psum_ctx.sv
// Partial-sum context stage sitting right after the FP FMA wrapper.
// Owns the accumulator fed back as the FMA addend, counts MACs per context,
// and hands finished sums to the shadow register on a context switch.
module fma_psum_ctx
    import fma_psum_pkg::*;
#(
    parameter int FP_W       = FP_W_DEFAULT,
    parameter int CNT_W      = 16,
    parameter bit PRELOAD_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_pipeline_en,
    input  logic             i_mac_valid,
    input  logic [FP_W-1:0]  i_fma_res,
    output logic [FP_W-1:0]  o_fma_c,
    input  logic             i_cswitch,
    input  logic [FP_W-1:0]  i_preload,
    input  logic             i_shift_en,
    input  logic [FP_W-1:0]  i_shift_in,
    input  logic             i_shift_in_vld,
    output logic [FP_W-1:0]  o_shift_out,
    output logic             o_shift_out_vld,
    output logic [CNT_W-1:0] o_mac_cnt,
    output logic             o_ovf
);

    localparam logic [FP_W-1:0]  ZERO    = FP_W'(FP_ZERO);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    psum_state_e state_q, state_d;

    logic [FP_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] macCnt_q, macCnt_d;
    logic             ovf_q, ovf_d;

    logic             switchEn;
    logic             ctxOpen;
    logic             captureEn;
    logic             ovfEv;
    logic             shiftEn;
    logic             shadowVld;
    logic             shadowVldNext;
    logic [FP_W-1:0]  shadowData;
    logic [FP_W-1:0]  preloadVal;

    // A stalled pipeline ignores the context switch entirely, addend included.
    assign switchEn   = i_pipeline_en & i_cswitch;
    assign preloadVal = PRELOAD_EN ? i_preload : ZERO;
    assign o_fma_c    = switchEn ? preloadVal : acc_q;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM outputs: capture, overflow and shift strobes derived from the state.
    always_comb begin
        ctxOpen   = (state_q != IDLE);
        captureEn = switchEn & ctxOpen & (i_shift_en | ~shadowVld);
        ovfEv     = switchEn & ctxOpen & ~i_shift_en & shadowVld;
        shiftEn   = i_pipeline_en & i_shift_en & ~captureEn;
        if (captureEn) begin
            shadowVldNext = 1'b1;
        end else if (shiftEn) begin
            shadowVldNext = i_shift_in_vld;
        end else begin
            shadowVldNext = shadowVld;
        end
    end

    // FSM next state: an open context is ACC_FULL exactly while the shadow is occupied.
    always_comb begin
        state_d = state_q;
        if (i_pipeline_en) begin
            case (state_q)
                IDLE: begin
                    if (i_cswitch) begin
                        state_d = shadowVldNext ? ACC_FULL : ACC;
                    end
                end
                ACC, ACC_FULL: begin
                    state_d = shadowVldNext ? ACC_FULL : ACC;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Accumulator and MAC counter: restart on a context switch, else accumulate.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (i_pipeline_en) begin
            if (i_cswitch) begin
                acc_d = i_mac_valid ? i_fma_res : preloadVal;
                cnt_d = i_mac_valid ? CNT_W'(1) : '0;
            end else if (i_mac_valid) begin
                acc_d = i_fma_res;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    // Completed-context count and sticky overflow flag.
    always_comb begin
        macCnt_d = captureEn ? cnt_q : macCnt_q;
        ovf_d    = ovf_q | ovfEv;
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            macCnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            macCnt_q <= macCnt_d;
            ovf_q    <= ovf_d;
        end
    end

    psum_shadow_reg #(
        .FP_W (FP_W)
    ) u_shadow (
        .clk_i          (i_clk),
        .rstn_i         (i_rstn),
        .capture_i      (captureEn),
        .capture_data_i (acc_q),
        .shift_i        (shiftEn),
        .shift_data_i   (i_shift_in),
        .shift_vld_i    (i_shift_in_vld),
        .data_o         (shadowData),
        .vld_o          (shadowVld)
    );

    assign o_shift_out     = shadowData;
    assign o_shift_out_vld = shadowVld;
    assign o_mac_cnt       = macCnt_q;
    assign o_ovf           = ovf_q;

endmodule

// File: tb/tb_fma_psum_ctx.sv
// Scoreboard bench for fma_psum_ctx: directed scenarios plus random traffic
// checked against a behavioural context/shadow model.
module tb_fma_psum_ctx;

    localparam int FP_W  = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             pipeEn = 1'b0;
    logic             macValid = 1'b0;
    logic [FP_W-1:0]  fmaRes = '0;
    logic [FP_W-1:0]  fmaC;
    logic             cswitch = 1'b0;
    logic [FP_W-1:0]  preload = '0;
    logic             shiftEn = 1'b0;
    logic [FP_W-1:0]  shiftIn = '0;
    logic             shiftInVld = 1'b0;
    logic [FP_W-1:0]  shiftOut;
    logic             shiftOutVld;
    logic [CNT_W-1:0] macCnt;
    logic             ovf;

    always #5 clk = ~clk;

    fma_psum_ctx #(
        .FP_W       (FP_W),
        .CNT_W      (CNT_W),
        .PRELOAD_EN (1'b1)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_pipeline_en   (pipeEn),
        .i_mac_valid     (macValid),
        .i_fma_res       (fmaRes),
        .o_fma_c         (fmaC),
        .i_cswitch       (cswitch),
        .i_preload       (preload),
        .i_shift_en      (shiftEn),
        .i_shift_in      (shiftIn),
        .i_shift_in_vld  (shiftInVld),
        .o_shift_out     (shiftOut),
        .o_shift_out_vld (shiftOutVld),
        .o_mac_cnt       (macCnt),
        .o_ovf           (ovf)
    );

    typedef struct {
        logic [FP_W-1:0]  fmaC;
        logic [FP_W-1:0]  shOut;
        logic             shVld;
        logic [CNT_W-1:0] macCnt;
        logic             ovf;
    } expect_t;

    expect_t expQ[$];

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit               mOpen = 0;
    logic [FP_W-1:0]  mAcc = '0;
    int unsigned      mCnt = 0;
    logic [FP_W-1:0]  mShadow = '0;
    bit               mSvld = 0;
    int unsigned      mLastCnt = 0;
    bit               mOvf = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the coming edge and queues expectations.
    task automatic applyStimulus(input bit rst, input bit en, input bit mv, input logic [FP_W-1:0] res,
                                 input bit cs, input logic [FP_W-1:0] pre, input bit sh,
                                 input logic [FP_W-1:0] shin, input bit shvld);
        expect_t e;
        logic [FP_W-1:0] oldAcc;
        int unsigned oldCnt;
        @(negedge clk);
        rstn = ~rst; pipeEn = en; macValid = mv; fmaRes = res; cswitch = cs;
        preload = pre; shiftEn = sh; shiftIn = shin; shiftInVld = shvld;
        e.fmaC = (en && cs) ? pre : mAcc;
        oldAcc = mAcc;
        oldCnt = mCnt;
        if (rst) begin
            mOpen = 0; mAcc = '0; mCnt = 0; mShadow = '0; mSvld = 0; mLastCnt = 0; mOvf = 0;
        end else if (en) begin
            if (cs) begin
                if (mOpen && (sh || !mSvld)) begin
                    mShadow = oldAcc; mSvld = 1; mLastCnt = oldCnt;
                end else if (mOpen) begin
                    mOvf = 1;
                end else if (sh) begin
                    mShadow = shin; mSvld = shvld;
                end
                mAcc = mv ? res : pre;
                mCnt = mv ? 1 : 0;
                mOpen = 1;
            end else begin
                if (sh) begin
                    mShadow = shin; mSvld = shvld;
                end
                if (mv) begin
                    mAcc = res;
                    if (mCnt < 65535) mCnt = mCnt + 1;
                end
            end
        end
        e.shOut = mShadow;
        e.shVld = mSvld;
        e.macCnt = CNT_W'(mLastCnt);
        e.ovf = mOvf;
        expQ.push_back(e);
    endtask

    task automatic idle(input bit en);
        applyStimulus(0, en, 0, '0, 0, '0, 0, '0, 0);
    endtask

    // Monitor: checks the combinational addend mid-cycle, registered outputs just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ[0];
                checkOutput("o_fma_c", 32'(fmaC), 32'(e.fmaC));
                @(posedge clk);
                #1;
                checkOutput("o_shift_out", 32'(shiftOut), 32'(e.shOut));
                checkOutput("o_shift_out_vld", 32'(shiftOutVld), 32'(e.shVld));
                checkOutput("o_mac_cnt", 32'(macCnt), 32'(e.macCnt));
                checkOutput("o_ovf", 32'(ovf), 32'(e.ovf));
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        int wait_cycles;
        // Reset
        applyStimulus(1, 1, 0, '0, 0, '0, 0, '0, 0);
        applyStimulus(1, 1, 0, '0, 0, '0, 0, '0, 0);

        // Three MACs, first one opens the context from a zero preload
        applyStimulus(0, 1, 1, 16'h3C00, 1, 16'h0000, 0, '0, 0);
        applyStimulus(0, 1, 1, 16'h4000, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 1, 16'h4200, 0, '0, 0, '0, 0);
        // Switch with preload 0x3800: captures 0x4200 with count 3
        applyStimulus(0, 1, 0, '0, 1, 16'h3800, 0, '0, 0);
        idle(1);

        // Stall while toggling control: nothing may move
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 16'(16'h1000 + i), i[0], 16'h5555, ~i[0], 16'hAAAA, 1);
        end

        // Second switch without shifting: overflow, shadow keeps 0x4200
        applyStimulus(0, 1, 1, 16'h4400, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 0, '0, 1, 16'h0000, 0, '0, 0);
        idle(1);

        // Fresh start: shadow=0x4200, acc=0x4500, then switch and shift together
        applyStimulus(1, 1, 0, '0, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 0, '0, 1, 16'h0000, 0, '0, 0);
        applyStimulus(0, 1, 1, 16'h4200, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 0, '0, 1, 16'h0000, 0, '0, 0);
        applyStimulus(0, 1, 1, 16'h4500, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 0, '0, 1, 16'h0000, 1, 16'h7777, 1);
        idle(1);

        // Reset during ACC_FULL, then the first switch must not capture
        applyStimulus(1, 1, 1, 16'h1234, 0, '0, 0, '0, 0);
        applyStimulus(0, 1, 1, 16'h2222, 1, 16'h3333, 0, '0, 0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 99) < 85),
                          ($urandom_range(0, 99) < 70),
                          16'($urandom_range(0, 16'hFFFF)),
                          ($urandom_range(0, 99) < 20),
                          16'($urandom_range(0, 16'hFFFF)),
                          ($urandom_range(0, 99) < 25),
                          16'($urandom_range(0, 16'hFFFF)),
                          ($urandom_range(0, 1) == 1));
        end

        // Drain the scoreboard with a bounded wait
        @(negedge clk);
        rstn = 1'b1; pipeEn = 1'b0; cswitch = 1'b0; shiftEn = 1'b0; macValid = 1'b0;
        wait_cycles = 0;
        while (expQ.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
